data_memo: RTL and testbench
============================

DATA_MEMO -- requirements
Module: data_memo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the byte-address width; capacity is 2^ADDR_WIDTH bytes, organised as 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all writes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port addr, input, ADDR_WIDTH, the byte address.
REQ-005 SHALL have port din, input, 32, the write data.
REQ-006 SHALL have port WE, input, 1, write enable; active high.
REQ-007 SHALL have port mode, input, 2, the access size: 00 word, 01 byte, 10 halfword, 11 word.
REQ-008 SHALL have port DataOut, output, 32, the read data.

Function
REQ-009 SHALL store data little-endian: byte lane k of a word (k = addr[1:0]) occupies bits 8k+7..8k.
REQ-010 SHALL perform a combinational read with zero-cycle latency: DataOut follows addr/mode/memory contents with no clock.
REQ-011 Word read SHALL return the word at addr[ADDR_WIDTH-1:2] and ignore addr[1:0].
REQ-012 Halfword read SHALL return the halfword selected by addr[1] (0 = bits 15:0, 1 = bits 31:16), zero-extended to 32 bits; addr[0] is ignored.
REQ-013 Byte read SHALL return the byte selected by addr[1:0], zero-extended to 32 bits.
REQ-014 When WE=1 at a rising clk edge with rst high, the write SHALL update memory per mode.
REQ-015 Word write SHALL write all 32 bits of din.
REQ-016 Halfword write SHALL write din[15:0] into the lane pair selected by addr[1].
REQ-017 Byte write SHALL write din[7:0] into the lane selected by addr[1:0].
REQ-018 Unselected byte lanes SHALL remain unchanged on halfword and byte writes.
REQ-019 When WE=0, memory SHALL NOT change.
REQ-020 Read-during-write to the same location SHALL show old data before the edge and new data immediately after the edge (no bypass).
REQ-021 Address SHALL NOT wrap or fault: every address is in range by construction of its width.

Reset
REQ-022 While rst=0, every memory location SHALL be asynchronously cleared to 0x00000000, and DataOut SHALL read 0.
REQ-023 A write whose clock edge coincides with rst=0 SHALL be discarded.
REQ-024 After rst deasserts, the first write SHALL take effect on the next rising clk edge.

Configuration
REQ-025 Macro DATA_MEMO_DBG_PORT_EN SHALL control a debug display port.
REQ-026 When DATA_MEMO_DBG_PORT_EN is defined, the block SHALL add input dbg_addr [ADDR_WIDTH-3:0] (word index) and output dbg_data [31:0].
REQ-027 With the debug port compiled in, dbg_data SHALL be a combinational word read independent of addr/mode, and SHALL be 0 during reset.
REQ-028 When DATA_MEMO_DBG_PORT_EN is not defined, those ports SHALL be absent and the block's function SHALL be otherwise identical.

Verification
REQ-029 Reset then word read: rst=0, then rst=1, mode=00, addr=0x000 -> DataOut=0x00000000; repeat for addr=0xFFC -> 0.
REQ-030 Word write/read: WE=1, mode=00, addr=0x010, din=0x12345678, one edge -> DataOut=0x12345678 at the same address; addr=0x013 also -> 0x12345678.
REQ-031 Byte read: after REQ-030, mode=01, addr=0x011 -> 0x00000056; addr=0x013 -> 0x00000012.
REQ-032 Byte/halfword write merge: mode=01, addr=0x012, din=0xFFFFFFAB, WE=1 -> word at 0x010 reads 0x12AB5678; then mode=10, addr=0x010, din=0x0000CAFE -> word reads 0x12ABCAFE; halfword read at addr=0x012 -> 0x000012AB.
REQ-033 WE low and mid-operation reset: WE=0 with din=0xDEADBEEF at 0x010 -> contents unchanged; then assert rst=0 between edges -> DataOut drops to 0 immediately, with no clock edge needed.
REQ-034 Debug port (macro defined): after writing 0xA5A5A5A5 to addr=0x020, dbg_addr=8 -> dbg_data=0xA5A5A5A5 while addr points elsewhere.

Source files
------------

// File: rtl/data_memo.sv
// ============================================================================
// data_memo : byte-addressable little-endian data memory, combinational read.
// Optional DATA_MEMO_DBG_PORT_EN adds a word-indexed debug read port. Rev 1.0
// ============================================================================
`default_nettype none

module data_memo #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    input  logic                  WE,
    input  logic [1:0]            mode,
`ifdef DATA_MEMO_DBG_PORT_EN
    output logic [31:0]           DataOut,
    input  logic [ADDR_WIDTH-3:0] dbg_addr,
    output logic [31:0]           dbg_data
`else
    output logic [31:0]           DataOut
`endif
);

    localparam int         C_WORDS   = 1 << (ADDR_WIDTH - 2);
    localparam logic [1:0] C_MODE_B  = 2'b01;
    localparam logic [1:0] C_MODE_H  = 2'b10;

    logic [31:0]           r_mem [C_WORDS];
    logic [ADDR_WIDTH-3:0] w_widx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_word;
    logic [31:0]           w_rdata;

    assign w_widx = addr[ADDR_WIDTH-1:2];

    // Narrow writes replicate the data across all lanes; the lane enable picks the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = din;
        case (mode)
            C_MODE_B: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{din[7:0]}};
            end
            C_MODE_H: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{din[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = din;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < C_WORDS; i++) begin : g_word
            for (genvar k = 0; k < 4; k++) begin : g_lane
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_mem[i][8*k +: 8] <= 8'h00;
                    end else if (WE && w_be[k] && (w_widx == i[ADDR_WIDTH-3:0])) begin
                        r_mem[i][8*k +: 8] <= w_wdata[8*k +: 8];
                    end
                end
            end
        end
    endgenerate

    assign w_word = r_mem[w_widx];

    always_comb begin
        w_rdata = w_word;
        case (mode)
            C_MODE_B: begin
                case (addr[1:0])
                    2'd0:    w_rdata = {24'h0, w_word[7:0]};
                    2'd1:    w_rdata = {24'h0, w_word[15:8]};
                    2'd2:    w_rdata = {24'h0, w_word[23:16]};
                    default: w_rdata = {24'h0, w_word[31:24]};
                endcase
            end
            C_MODE_H: w_rdata = addr[1] ? {16'h0, w_word[31:16]} : {16'h0, w_word[15:0]};
            default:  w_rdata = w_word;
        endcase
    end

    assign DataOut = rst ? w_rdata : 32'h0;

`ifdef DATA_MEMO_DBG_PORT_EN
    assign dbg_data = rst ? r_mem[dbg_addr] : 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memo.sv
// ============================================================================
// tb_data_memo : randomized self-checking bench for data_memo against a byte
// array reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_memo;

    localparam int AW  = 12;
    localparam int NBY = 1 << AW;

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          WE   = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   din  = '0;
    logic [1:0]    mode = '0;
    logic [31:0]   DataOut;
`ifdef DATA_MEMO_DBG_PORT_EN
    logic [AW-3:0] dbg_addr = '0;
    logic [31:0]   dbg_data;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_mem [NBY];

    data_memo #(.ADDR_WIDTH(AW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .din      (din),
        .WE       (WE),
        .mode     (mode),
`ifdef DATA_MEMO_DBG_PORT_EN
        .DataOut  (DataOut),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`else
        .DataOut  (DataOut)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBY; i++) m_mem[i] = 8'h00;
    endtask

    function automatic logic [31:0] ref_read(input int unsigned a, input logic [1:0] m);
        int unsigned w;
        int unsigned h;
        w = a & ~32'd3;
        h = a & ~32'd1;
        case (m)
            2'b01:   return {24'h0, m_mem[a]};
            2'b10:   return {16'h0, m_mem[h+1], m_mem[h]};
            default: return {m_mem[w+3], m_mem[w+2], m_mem[w+1], m_mem[w]};
        endcase
    endfunction

    task automatic ref_write(input int unsigned a, input logic [1:0] m, input logic [31:0] d);
        int unsigned w;
        int unsigned h;
        w = a & ~32'd3;
        h = a & ~32'd1;
        case (m)
            2'b01: m_mem[a] = d[7:0];
            2'b10: begin
                m_mem[h]   = d[7:0];
                m_mem[h+1] = d[15:8];
            end
            default: for (int b = 0; b < 4; b++) m_mem[w+b] = d[8*b +: 8];
        endcase
    endtask

    // One access: check old data before the edge, new data just after it.
    task automatic cycle(input logic we, input logic [1:0] m, input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = we; mode = m; addr = a; din = d;
`ifdef DATA_MEMO_DBG_PORT_EN
        dbg_addr = AW'($urandom_range(0, 15));
`endif
        #1;
        check_eq("pre_edge", DataOut, ref_read(a, m));
`ifdef DATA_MEMO_DBG_PORT_EN
        check_eq("dbg_rd", dbg_data, ref_read({dbg_addr, 2'b00}, 2'b00));
`endif
        @(posedge clk);
        #1;
        if (we && rst) ref_write(a, m, d);
        check_eq("post_edge", DataOut, ref_read(a, m));
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] m, input logic [AW-1:0] a, input logic [31:0] exp);
        @(negedge clk);
        WE = 1'b0; mode = m; addr = a;
        #1;
        check_eq(tag, DataOut, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_eq("rst_async", DataOut, 32'h0);
`ifdef DATA_MEMO_DBG_PORT_EN
        check_eq("dbg_rst", dbg_data, 32'h0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [1:0]    rm;
        model_clear();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_eq("in_reset", DataOut, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        rd("rst_w000", 2'b00, 12'h000, 32'h0);
        rd("rst_wFFC", 2'b00, 12'hFFC, 32'h0);

        cycle(1'b1, 2'b00, 12'h010, 32'h12345678);
        rd("w_010", 2'b00, 12'h010, 32'h12345678);
        rd("w_013", 2'b00, 12'h013, 32'h12345678);
        rd("b_011", 2'b01, 12'h011, 32'h00000056);
        rd("b_013", 2'b01, 12'h013, 32'h00000012);

        cycle(1'b1, 2'b01, 12'h012, 32'hFFFFFFAB);
        rd("merge_b", 2'b00, 12'h010, 32'h12AB5678);
        cycle(1'b1, 2'b10, 12'h010, 32'h0000CAFE);
        rd("merge_h", 2'b00, 12'h010, 32'h12ABCAFE);
        rd("h_012", 2'b10, 12'h012, 32'h000012AB);
        rd("w_mode11", 2'b11, 12'h011, 32'h12ABCAFE);

        cycle(1'b0, 2'b00, 12'h010, 32'hDEADBEEF);
        rd("we_low", 2'b00, 12'h010, 32'h12ABCAFE);

        // Reset between edges, then a write attempted while reset is held.
        @(negedge clk);
        mode = 2'b00; addr = 12'h010;
        #2 rst = 1'b0;
        #1 check_eq("mid_rst", DataOut, 32'h0);
        model_clear();
        WE = 1'b1; din = 32'h55AA55AA;
        @(posedge clk);
        #1 WE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd("wr_in_rst", 2'b00, 12'h010, 32'h0);
        cycle(1'b1, 2'b00, 12'h010, 32'h11223344);
        rd("first_wr", 2'b00, 12'h010, 32'h11223344);

`ifdef DATA_MEMO_DBG_PORT_EN
        cycle(1'b1, 2'b00, 12'h020, 32'hA5A5A5A5);
        @(negedge clk);
        dbg_addr = 10'd8; addr = 12'h010; mode = 2'b01;
        #1 check_eq("dbg_020", dbg_data, 32'hA5A5A5A5);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) ra = AW'(NBY - 1 - $urandom_range(0, 15));
                else                           ra = AW'($urandom_range(0, 63));
                rm = 2'($urandom_range(0, 3));
                cycle(1'($urandom_range(0, 2) != 0), rm, ra, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
